// File: rtl/pa_pkg.sv
// Shared types and default sizes for the PE-array operand feed path.
package pa_pkg;

  localparam int PA_SIZE_MAT   = 16;
  localparam int PA_WIDTH_DATA = 16;
  localparam int PA_BUS_W      = PA_SIZE_MAT * PA_WIDTH_DATA;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FEED  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  typedef struct packed {
    logic [PA_BUS_W-1:0] h;
    logic [PA_BUS_W-1:0] v;
  } pair_t;

endpackage

// File: rtl/pa_pair_fifo.sv
// Operand-pair FIFO; a push is accepted when full only if a pop frees the head slot in the same cycle.
module pa_pair_fifo
  import pa_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk_pe,
  input  logic                          rst_n,
  input  logic                          i_push,
  input  logic                          i_pop,
  input  pair_t                         i_data,
  output pair_t                         o_head,
  output logic                          o_full,
  output logic                          o_empty,
  output logic [$clog2(FIFO_DEPTH):0]   o_level
);

  localparam int               W_PTR    = $clog2(FIFO_DEPTH);
  localparam logic [W_PTR:0]   LVL_FULL = (W_PTR + 1)'(FIFO_DEPTH);

  pair_t              r_mem [FIFO_DEPTH];
  logic [W_PTR-1:0]   r_wr_ptr;
  logic [W_PTR-1:0]   r_rd_ptr;
  logic [W_PTR:0]     r_level;
  logic               w_push_ok;
  logic               w_pop_ok;

  assign o_full    = (r_level == LVL_FULL);
  assign o_empty   = (r_level == '0);
  assign w_pop_ok  = i_pop && !o_empty;
  assign w_push_ok = i_push && (!o_full || w_pop_ok);
  assign o_head    = r_mem[r_rd_ptr];
  assign o_level   = r_level;

  // NOTE: storage has no reset; pointers and level decide which entries are valid.
  always_ff @(posedge clk_pe) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_pe) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/pa_feed_sched.sv
// Pairs incoming row beats into H/V operands, queues them, and feeds the PE array one tile at a time.
module pa_feed_sched
  import pa_pkg::*;
#(
  parameter int  SIZE_MAT   = PA_SIZE_MAT,
  parameter int  WIDTH_DATA = PA_WIDTH_DATA,
  parameter int  FIFO_DEPTH = 4,
  parameter int  N_RESULT   = 256,
  localparam int BUS_W      = SIZE_MAT * WIDTH_DATA
) (
  input  logic                        clk_pe,
  input  logic                        rst_n,
  input  logic                        in_valid_i,
  input  logic [BUS_W-1:0]            in_data_i,
  input  logic                        pa_read_en_i,
  input  logic                        pa_result_valid_i,
  output logic                        pa_data_rdy_o,
  output logic [BUS_W-1:0]            pa_h_bus_o,
  output logic [BUS_W-1:0]            pa_v_bus_o,
  output logic                        tile_done_o,
  output logic                        busy_o,
  output logic                        overflow_o,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level_o,
  output logic [7:0]                  tile_cnt_o
);

  localparam int               W_POP    = $clog2(SIZE_MAT + 1);
  localparam int               W_RES    = $clog2(N_RESULT + 1);
  localparam logic [W_POP-1:0] POP_LAST = W_POP'(SIZE_MAT - 1);
  localparam logic [W_RES-1:0] RES_FULL = W_RES'(N_RESULT);

  state_e                      r_state;
  logic                        r_phase;
  logic [BUS_W-1:0]            r_h_hold;
  logic [W_POP-1:0]            r_pop_cnt;
  logic [W_RES-1:0]            r_res_cnt;
  logic [BUS_W-1:0]            r_h_bus;
  logic [BUS_W-1:0]            r_v_bus;
  logic                        r_tile_done;
  logic                        r_overflow;
  logic [7:0]                  r_tile_cnt;

  logic                        w_push;
  logic                        w_pop;
  logic                        w_full;
  logic                        w_empty;
  logic                        w_last_pop;
  logic                        w_finish;
  logic [W_RES-1:0]            w_res_next;
  logic [$clog2(FIFO_DEPTH):0] w_level;
  pair_t                       w_push_pair;
  pair_t                       w_head;

  assign w_push      = in_valid_i && r_phase;
  assign w_push_pair = '{h: r_h_hold, v: in_data_i};

  assign pa_data_rdy_o = (r_state == ST_FEED) && !w_empty;
  assign w_pop         = pa_read_en_i && pa_data_rdy_o;
  assign w_last_pop    = w_pop && (r_pop_cnt == POP_LAST);

  // NOTE: always_comb outputs get a default first so no path can infer a latch.
  always_comb begin
    w_res_next = r_res_cnt;
    if ((r_state != ST_IDLE) && pa_result_valid_i && (r_res_cnt != RES_FULL))
      w_res_next = r_res_cnt + 1'b1;
  end

  // A tile closes from DRAIN, or straight from FEED when the last pop meets the final result.
  assign w_finish = (w_res_next == RES_FULL) &&
                    (((r_state == ST_FEED) && w_last_pop) || (r_state == ST_DRAIN));

  pa_pair_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_pe  (clk_pe),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_push_pair),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (w_level)
  );

  always_ff @(posedge clk_pe) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_phase     <= 1'b0;
      r_h_hold    <= '0;
      r_pop_cnt   <= '0;
      r_res_cnt   <= '0;
      r_h_bus     <= '0;
      r_v_bus     <= '0;
      r_tile_done <= 1'b0;
      r_overflow  <= 1'b0;
      r_tile_cnt  <= '0;
    end else begin
      r_tile_done <= 1'b0;
      r_res_cnt   <= w_res_next;

      if (in_valid_i) begin
        r_phase <= !r_phase;
        if (!r_phase) r_h_hold <= in_data_i;
      end

      if (w_push && w_full && !w_pop) r_overflow <= 1'b1;

      if (w_pop) begin
        r_h_bus   <= w_head.h;
        r_v_bus   <= w_head.v;
        r_pop_cnt <= r_pop_cnt + 1'b1;
      end

      case (r_state)
        ST_IDLE:  if (!w_empty)   r_state <= ST_FEED;
        ST_FEED:  if (w_last_pop) r_state <= ST_DRAIN;
        ST_DRAIN: r_state <= ST_DRAIN;
        default:  r_state <= ST_IDLE;
      endcase

      if (w_finish) begin
        r_state     <= ST_IDLE;
        r_tile_done <= 1'b1;
        r_tile_cnt  <= r_tile_cnt + 1'b1;
        r_pop_cnt   <= '0;
        r_res_cnt   <= '0;
      end
    end
  end

  assign pa_h_bus_o   = r_h_bus;
  assign pa_v_bus_o   = r_v_bus;
  assign tile_done_o  = r_tile_done;
  assign busy_o       = (r_state != ST_IDLE);
  assign overflow_o   = r_overflow;
  assign fifo_level_o = w_level;
  assign tile_cnt_o   = r_tile_cnt;

endmodule
